// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter in front of a register file write port, with an optional
// per-register pending-write scoreboard enabled by defining REGFILE_ARB_SCOREBOARD_EN.
module regfile_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ReqV0,
    input  logic [ADDR_W-1:0]        ReqA0,
    input  logic [DATA_W-1:0]        ReqD0,
    output logic                     ReqR0,
    input  logic                     ReqV1,
    input  logic [ADDR_W-1:0]        ReqA1,
    input  logic [DATA_W-1:0]        ReqD1,
    output logic                     ReqR1,
    input  logic                     ResvV,
    input  logic [ADDR_W-1:0]        ResvA,
    output logic                     WE3,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WD3,
    output logic [(1<<ADDR_W)-1:0]   Busy,
    output logic                     Idle
);

    localparam int NREG = 1 << ADDR_W;

    // Handshake: a requester transfers when ReqVn and ReqRn are both high at a rising edge.
    // ReqRn depends only on buffer state and the current grant, never on ReqVn.
    logic              buf_v0, buf_v1;
    logic [ADDR_W-1:0] buf_a0, buf_a1;
    logic [DATA_W-1:0] buf_d0, buf_d1;
    logic              last;

    logic              gnt0, gnt1, gnt_any;
    logic [ADDR_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_d;

    // With both buffers valid the requester that did not win last time is served.
    always_comb begin
        gnt0    = buf_v0 & (~buf_v1 | last);
        gnt1    = buf_v1 & (~buf_v0 | ~last);
        gnt_any = gnt0 | gnt1;
        sel_a   = gnt0 ? buf_a0 : buf_a1;
        sel_d   = gnt0 ? buf_d0 : buf_d1;
    end

    assign ReqR0 = ~buf_v0 | gnt0;
    assign ReqR1 = ~buf_v1 | gnt1;
    assign Idle  = ~buf_v0 & ~buf_v1 & ~WE3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_v0 <= 1'b0;
            buf_a0 <= '0;
            buf_d0 <= '0;
        end else if (ReqV0 && ReqR0) begin
            buf_v0 <= 1'b1;
            buf_a0 <= ReqA0;
            buf_d0 <= ReqD0;
        end else if (gnt0) begin
            buf_v0 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_v1 <= 1'b0;
            buf_a1 <= '0;
            buf_d1 <= '0;
        end else if (ReqV1 && ReqR1) begin
            buf_v1 <= 1'b1;
            buf_a1 <= ReqA1;
            buf_d1 <= ReqD1;
        end else if (gnt1) begin
            buf_v1 <= 1'b0;
        end
    end

    // Address 0 is dequeued like any other write but never raises WE3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b1;
            WE3  <= 1'b0;
            A3   <= '0;
            WD3  <= '0;
        end else if (gnt_any) begin
            last <= gnt1;
            WE3  <= (sel_a != '0);
            A3   <= sel_a;
            WD3  <= sel_d;
        end else begin
            WE3  <= 1'b0;
        end
    end

`ifdef REGFILE_ARB_SCOREBOARD_EN
    logic [NREG-1:0] busy_q, busy_d;

    // Clear is applied before set so a same-edge reservation of the retiring register wins.
    always_comb begin
        busy_d = busy_q;
        if (WE3) busy_d[A3] = 1'b0;
        if (ResvV && (ResvA != '0)) busy_d[ResvA] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign Busy = busy_q;
`else
    logic unused_resv;
    assign unused_resv = ^{ResvV, ResvA};
    assign Busy        = {NREG{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, conflicts, back-to-back,
// x0 write, scoreboard (when REGFILE_ARB_SCOREBOARD_EN is defined) and async reset.
module tb_regfile_write_arbiter;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              ReqV0, ReqV1, ReqR0, ReqR1;
    logic [ADDR_W-1:0] ReqA0, ReqA1, ResvA, A3;
    logic [DATA_W-1:0] ReqD0, ReqD1, WD3;
    logic              ResvV, WE3, Idle;
    logic [NREG-1:0]   Busy;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ReqV0(ReqV0), .ReqA0(ReqA0), .ReqD0(ReqD0), .ReqR0(ReqR0),
        .ReqV1(ReqV1), .ReqA1(ReqA1), .ReqD1(ReqD1), .ReqR1(ReqR1),
        .ResvV(ResvV), .ResvA(ResvA),
        .WE3(WE3), .A3(A3), .WD3(WD3), .Busy(Busy), .Idle(Idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        check({tag, "_we"}, 64'(WE3), 64'(1));
        check({tag, "_a"}, 64'(A3), 64'(a));
        check({tag, "_d"}, 64'(WD3), 64'(d));
    endtask

    logic [ADDR_W-1:0] b2b_a [4];
    logic [DATA_W-1:0] b2b_d [4];
    logic [NREG-1:0]   busy_before;

    initial begin
        b2b_a[0] = 5'd1;  b2b_d[0] = 32'h0000_1111;
        b2b_a[1] = 5'd2;  b2b_d[1] = 32'h0000_2222;
        b2b_a[2] = 5'd12; b2b_d[2] = 32'h0000_3333;
        b2b_a[3] = 5'd31; b2b_d[3] = 32'h0000_4444;

        rst = 1'b0;
        ReqV0 = 0; ReqA0 = '0; ReqD0 = '0;
        ReqV1 = 0; ReqA1 = '0; ReqD1 = '0;
        ResvV = 0; ResvA = '0;
        #23;
        check("rst_we3", 64'(WE3), 64'(0));
        check("rst_a3", 64'(A3), 64'(0));
        check("rst_wd3", 64'(WD3), 64'(0));
        check("rst_idle", 64'(Idle), 64'(1));
        check("rst_busy", 64'(Busy), 64'(0));
        check("rst_r0", 64'(ReqR0), 64'(1));
        check("rst_r1", 64'(ReqR1), 64'(1));
        rst = 1'b1;
        tick();

        // Conflict right after reset: requester 0 first.
        ReqV0 = 1; ReqA0 = 5'd3; ReqD0 = 32'h11;
        ReqV1 = 1; ReqA1 = 5'd4; ReqD1 = 32'h22;
        tick();
        ReqV0 = 0; ReqV1 = 0;
        check("cf1_r0", 64'(ReqR0), 64'(1));
        check("cf1_r1", 64'(ReqR1), 64'(0));
        tick();
        check_wr("cf1_first", 5'd3, 32'h11);
        tick();
        check_wr("cf1_second", 5'd4, 32'h22);
        tick();
        check("cf1_done_we", 64'(WE3), 64'(0));
        check("cf1_done_idle", 64'(Idle), 64'(1));

        // Single write with latency check.
        ReqV0 = 1; ReqA0 = 5'd5; ReqD0 = 32'hDEADBEEF;
        tick();
        ReqV0 = 0;
        check("sw_we_k", 64'(WE3), 64'(0));
        check("sw_idle_k", 64'(Idle), 64'(0));
        tick();
        check_wr("sw_k1", 5'd5, 32'hDEADBEEF);
        check("sw_idle_k1", 64'(Idle), 64'(0));
        tick();
        check("sw_we_k2", 64'(WE3), 64'(0));
        check("sw_idle_k2", 64'(Idle), 64'(1));
        check("sw_a3_hold", 64'(A3), 64'(5));
        check("sw_wd3_hold", 64'(WD3), 64'(32'hDEADBEEF));

        // Requester 0 won last, so the repeated conflict serves requester 1 first.
        ReqV0 = 1; ReqA0 = 5'd9;  ReqD0 = 32'h33;
        ReqV1 = 1; ReqA1 = 5'd10; ReqD1 = 32'h44;
        tick();
        ReqV0 = 0; ReqV1 = 0;
        check("cf2_r0", 64'(ReqR0), 64'(0));
        check("cf2_r1", 64'(ReqR1), 64'(1));
        tick();
        check_wr("cf2_first", 5'd10, 32'h44);
        tick();
        check_wr("cf2_second", 5'd9, 32'h33);
        tick();
        check("cf2_done_we", 64'(WE3), 64'(0));

        // Back-to-back from requester 0.
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) begin
                ReqV0 = 1; ReqA0 = b2b_a[cyc]; ReqD0 = b2b_d[cyc];
                check($sformatf("b2b_r0_%0d", cyc), 64'(ReqR0), 64'(1));
            end else begin
                ReqV0 = 0;
            end
            tick();
            if (cyc >= 1 && cyc <= 4)
                check_wr($sformatf("b2b_wr_%0d", cyc - 1), b2b_a[cyc-1], b2b_d[cyc-1]);
            else
                check($sformatf("b2b_we_%0d", cyc), 64'(WE3), 64'(0));
        end

        // Write to x0: dequeued but never written.
        busy_before = Busy;
        ReqV1 = 1; ReqA1 = 5'd0; ReqD1 = 32'hFFFFFFFF;
        check("x0_r1", 64'(ReqR1), 64'(1));
        tick();
        ReqV1 = 0;
        check("x0_idle_k", 64'(Idle), 64'(0));
        tick();
        check("x0_we", 64'(WE3), 64'(0));
        check("x0_idle", 64'(Idle), 64'(1));
        check("x0_busy", 64'(Busy), 64'(busy_before));

`ifdef REGFILE_ARB_SCOREBOARD_EN
        ResvV = 1; ResvA = 5'd7;
        tick();
        ResvV = 0;
        check("sb_set", 64'(Busy), 64'(32'h80));
        ReqV0 = 1; ReqA0 = 5'd7; ReqD0 = 32'h77;
        tick();
        ReqV0 = 0;
        check("sb_hold_k", 64'(Busy), 64'(32'h80));
        tick();
        check_wr("sb_wr", 5'd7, 32'h77);
        check("sb_hold_k1", 64'(Busy), 64'(32'h80));
        tick();
        check("sb_clear", 64'(Busy), 64'(0));
        // Reservation at the very edge the write retires keeps the flag set.
        ResvV = 1; ResvA = 5'd7;
        tick();
        ResvV = 0;
        ReqV0 = 1; ReqA0 = 5'd7; ReqD0 = 32'h78;
        tick();
        ReqV0 = 0;
        tick();
        check_wr("sb_wr2", 5'd7, 32'h78);
        ResvV = 1; ResvA = 5'd7;
        tick();
        ResvV = 0;
        check("sb_set_wins", 64'(Busy), 64'(32'h80));
        ResvV = 1; ResvA = 5'd0;
        tick();
        ResvV = 0;
        check("sb_x0_resv", 64'(Busy), 64'(32'h80));
`else
        ResvV = 1; ResvA = 5'd7;
        tick();
        ResvV = 0;
        check("nosb_busy", 64'(Busy), 64'(0));
`endif

        // Async reset between edges with both buffers full.
        ReqV0 = 1; ReqA0 = 5'd1; ReqD0 = 32'hA1;
        ReqV1 = 1; ReqA1 = 5'd7; ReqD1 = 32'hB7;
        tick();
        ReqV0 = 0; ReqV1 = 0;
        check("ar_full_idle", 64'(Idle), 64'(0));
        check("ar_full_rdy", 64'(ReqR0 & ReqR1), 64'(0));
        tick();
        check("ar_we_before", 64'(WE3), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("ar_we3", 64'(WE3), 64'(0));
        check("ar_busy", 64'(Busy), 64'(0));
        check("ar_r0", 64'(ReqR0), 64'(1));
        check("ar_r1", 64'(ReqR1), 64'(1));
        check("ar_idle", 64'(Idle), 64'(1));
        check("ar_a3", 64'(A3), 64'(0));
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("ar_post_we", 64'(WE3), 64'(0));
        check("ar_post_idle", 64'(Idle), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 5, register address width; DATA_W, default 32, write data width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ReqV0 / ReqA0 / ReqD0  input  1 / ADDR_W / DATA_W  requester 0 (pipeline writeback) valid, destination, data.
REQ-005 ReqR0  output  1  requester 0 ready; transfer SHALL occur when ReqV0 and ReqR0 are both high at a rising edge.
REQ-006 ReqV1 / ReqA1 / ReqD1 / ReqR1  in / in / in / out  1 / ADDR_W / DATA_W / 1  requester 1 (long-latency unit), same handshake.
REQ-007 ResvV / ResvA  input  1 / ADDR_W  scoreboard reservation strobe and destination address.
REQ-008 WE3 / A3 / WD3  output  1 / ADDR_W / DATA_W  registered write port driving the register file.
REQ-009 Busy  output  2^ADDR_W  per-register pending-write flags.
REQ-010 Idle  output  1  high when both buffers are empty and WE3 is low.

Function
REQ-011 Each requester SHALL own a one-entry buffer (BufV, address, data) loaded on a handshake.
REQ-012 ReqRn SHALL be combinational: ~BufVn | GntN; enqueue into a buffer granted in the same cycle is allowed.
REQ-013 Grant SHALL go to the only valid buffer; when both are valid, it SHALL go to the requester other than Last; Last SHALL update to the granted index.
REQ-014 On a grant, at the next edge: WE3 <= (granted address != 0); A3, WD3 <= granted entry; the buffer SHALL empty unless refilled the same edge.
REQ-015 With no grant, WE3 SHALL be 0 at the next edge; A3 and WD3 SHALL hold.
REQ-016 Latency: handshake at edge k -> WE3 high after edge k+1 -> register file write at edge k+2; one write per cycle maximum.
REQ-017 Writes to address 0 SHALL be accepted and dequeued, but WE3 SHALL stay low.
REQ-018 Busy[ResvA] SHALL set at an edge where ResvV is high and ResvA != 0.
REQ-019 Busy[A3] SHALL clear at an edge where WE3 is high, coincident with the register file capturing the data.
REQ-020 When set and clear target the same address at the same edge, set SHALL win.
REQ-021 Busy[0] SHALL always read 0.
REQ-022 A write to a non-busy register SHALL proceed normally without error.

Reset
REQ-023 While rst is low, the following SHALL be forced immediately: BufV0=BufV1=0, Last=1 (requester 0 wins first conflict), WE3=0, A3=0, WD3=0, Busy=0, Idle=1.
REQ-024 Reset mid-operation SHALL discard buffered and in-flight writes; ReqRn SHALL be 1 after release.

Configuration
REQ-025 With macro REGFILE_ARB_SCOREBOARD_EN defined, Busy SHALL behave as in REQ-018..REQ-021.
REQ-026 Without REGFILE_ARB_SCOREBOARD_EN, Busy SHALL be constant 0, ResvV and ResvA SHALL be ignored, and no scoreboard flops SHALL exist; all other behaviour SHALL be unchanged.

Verification
REQ-027 Single write: ReqV0=1, ReqA0=5, ReqD0=0xDEADBEEF for one cycle at edge k -> WE3=1, A3=5, WD3=0xDEADBEEF during the cycle after edge k+1; Idle=1 after edge k+2.
REQ-028 Conflict: both buffers loaded at the same edge (A=3/D=0x11, A=4/D=0x22) after reset -> requester 0 writes first, requester 1 the next cycle; a repeated conflict alternates order.
REQ-029 Back-to-back: ReqV0 held high with 4 distinct writes -> ReqR0 stays 1, WE3 high 4 consecutive cycles, in order.
REQ-030 x0 write: ReqA1=0, ReqD1=0xFFFFFFFF -> handshake completes, WE3 stays 0, Busy unchanged.
REQ-031 Scoreboard (macro defined): ResvV with ResvA=7 -> Busy[7]=1; write 7 issued -> Busy[7] clears at the WE3 edge; ResvA=7 at that same edge -> Busy[7] stays 1.
REQ-032 Async reset: assert rst low between edges with both buffers full and Busy=0x80 -> WE3=0, Busy=0, ReqR0=ReqR1=1 without a clock edge.
